icache_tag_ctrl: RTL
====================

# icache_tag_ctrl

- 16-line, direct-mapped instruction-cache tag store and miss controller for the RV32IM fetch stage.
- Stores one 28-bit block address (PC[31:4]) and a valid bit per line, and exports all 16 tags as a flattened bus to the 16:1 28-bit tag select mux.
- The mux returns the selected tag. The block compares it against the fetch address, stalls the pipeline on a miss, sequences the line fill from instruction memory, and then updates the tag and valid bit.

## Interface
Parameters:
- none (geometry is fixed at 16 lines × 16-byte blocks).

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- READ  in  1  fetch request from the PC stage.
- ADDRESS  in  32  fetch byte address; index = ADDRESS[7:4], block address = ADDRESS[31:4].
- SELECTED_TAG  in  28  tag returned by the downstream 16:1 mux (driven with SELECT = ADDRESS[7:4]).
- MEM_BUSYWAIT  in  1  instruction memory busy; low = fill data ready.
- FLUSH  in  1  invalidate all lines (present only with ICACHE_FLUSH_EN).
- TAG_ARRAY  out  448  line i tag at [28*i+27 : 28*i]; feeds the mux inputs INPUT1..INPUT16 in order.
- VALID_ARRAY  out  16  valid bit per line.
- BUSYWAIT  out  1  pipeline stall request.
- MEM_READ  out  1  instruction memory read strobe.
- MEM_ADDRESS  out  28  block address of the fill.
- FILL_EN  out  1  one-cycle pulse telling the data array to write the fetched block into the latched index.

## Operation
- HIT = VALID_ARRAY[ADDRESS[7:4]] && (SELECTED_TAG == ADDRESS[31:4]). This is a full 28-bit equality; the index bits are stored redundantly by design.
- FSM states are IDLE, FETCH and UPDATE.
- IDLE:
  - If READ && !HIT: BUSYWAIT = 1 combinationally, latch ADDRESS[31:4] into MISS_BLK, go to FETCH.
  - If READ && HIT: BUSYWAIT = 0.
  - If !READ: BUSYWAIT = 0.
- FETCH:
  - MEM_READ = 1, MEM_ADDRESS = MISS_BLK, BUSYWAIT = 1.
  - When MEM_BUSYWAIT = 0 at the edge, go to UPDATE; otherwise stay.
- UPDATE:
  - FILL_EN = 1, BUSYWAIT = 1, MEM_READ = 0.
  - At the edge: tag[MISS_BLK[3:0]] ← MISS_BLK, valid[MISS_BLK[3:0]] ← 1, go to IDLE.
- After UPDATE, the IDLE cycle re-evaluates HIT against the now-updated tag. For an unchanged ADDRESS this is a hit.
- Fills always use the latched MISS_BLK. Changes on ADDRESS or READ during FETCH or UPDATE are ignored; the fill always completes.
- A miss evicts the resident line unconditionally. Lines are never dirty, so there is no write-back.

## Timing
- Reset values: state = IDLE, all valid = 0, all tags = 0, MISS_BLK = 0. TAG_ARRAY = 0, VALID_ARRAY = 0, MEM_READ = 0, FILL_EN = 0, MEM_ADDRESS = 0.
- BUSYWAIT immediately after reset is combinational: it is 1 only if READ is high, because every lookup misses.
- Hit latency: 0 cycles; BUSYWAIT stays low in the request cycle.
- Miss latency: 1 (detect) + N (FETCH cycles until MEM_BUSYWAIT is sampled low, N ≥ 1) + 1 (UPDATE).
  - BUSYWAIT drops in the following IDLE cycle.
  - Minimum total stall: 3 cycles.
- MEM_READ is a registered-state decode. It is high for exactly the FETCH cycles and never glitches into UPDATE.
- RESET mid-miss (FETCH or UPDATE):
  - At that edge: state → IDLE, MEM_READ = 0 and FILL_EN = 0 from the next cycle, no tag or valid write.
  - Instruction memory must tolerate a withdrawn MEM_READ.
- RESET takes priority over every other input, including FLUSH.

## Configuration
- `ICACHE_FLUSH_EN` defined:
  - The FLUSH port exists.
  - FLUSH high at an edge while in IDLE clears all 16 valid bits at that edge; tags are kept. BUSYWAIT for that cycle follows the pre-flush HIT.
  - FLUSH seen in FETCH or UPDATE sets a pending flag. The flag is applied at the first IDLE edge, so the just-filled line is also invalidated.
  - Pending flush is cleared by RESET.
- `ICACHE_FLUSH_EN` undefined: no FLUSH port, no pending flag; valid bits are cleared only by RESET.

## Test plan
- **Reset:** hold RESET 2 cycles → VALID_ARRAY = 16'h0000, TAG_ARRAY = 0, MEM_READ = 0. Then READ, ADDRESS = 32'h0000_0040 → BUSYWAIT = 1.
- **Cold miss fill:** ADDRESS = 32'h0000_1234, MEM_BUSYWAIT high for 4 cycles then low →
  - MEM_READ high for 5 cycles, MEM_ADDRESS = 28'h0000123.
  - FILL_EN pulses once; then VALID_ARRAY[3] = 1 and tag 3 = 28'h0000123.
  - BUSYWAIT low on the next cycle.
- **Hit:** repeat ADDRESS = 32'h0000_1238 → BUSYWAIT = 0 in the same cycle, MEM_READ stays 0.
- **Conflict miss:** ADDRESS = 32'h0001_0030 (same index 3) → miss, fill with MEM_ADDRESS = 28'h0001003; tag 3 is replaced; 32'h0000_1234 then misses again.
- **Reset mid-FETCH:** assert RESET on the 2nd FETCH cycle → MEM_READ = 0 the next cycle, VALID_ARRAY = 0, no FILL_EN pulse.
- **Flush (ICACHE_FLUSH_EN):**
  - Fill indices 0 and 5, pulse FLUSH in IDLE → VALID_ARRAY = 0 next cycle.
  - Pulse FLUSH during FETCH → the line filled by that miss reads invalid after return to IDLE.

Source files
------------

// File: rtl/icache_tag_ctrl.sv
// Direct-mapped 16-line instruction-cache tag store and miss controller.
// Optional whole-cache invalidate via FLUSH is built only when ICACHE_FLUSH_EN is defined.
module icache_tag_ctrl (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         READ,
    input  logic [31:0]  ADDRESS,
    input  logic [27:0]  SELECTED_TAG,
    input  logic         MEM_BUSYWAIT,
`ifdef ICACHE_FLUSH_EN
    input  logic         FLUSH,
`endif
    output logic [447:0] TAG_ARRAY,
    output logic [15:0]  VALID_ARRAY,
    output logic         BUSYWAIT,
    output logic         MEM_READ,
    output logic [27:0]  MEM_ADDRESS,
    output logic         FILL_EN
);

    typedef enum logic [1:0] {IDLE, FETCH, UPDATE} state_t;

    state_t            state_q, state_d;
    logic [15:0][27:0] tags_q, tags_d;
    logic [15:0]       valid_q, valid_d;
    logic [27:0]       miss_blk_q, miss_blk_d;
    logic              hit;
    logic              busywait;
    logic              unused_offset_bits;

`ifdef ICACHE_FLUSH_EN
    logic flush_pend_q, flush_pend_d;
`endif

    // Byte offset within a block plays no part in the lookup.
    assign unused_offset_bits = ^ADDRESS[3:0];

    assign hit = valid_q[ADDRESS[7:4]] && (SELECTED_TAG == ADDRESS[31:4]);

    always_comb begin
        state_d    = state_q;
        tags_d     = tags_q;
        valid_d    = valid_q;
        miss_blk_d = miss_blk_q;
        busywait   = 1'b0;
`ifdef ICACHE_FLUSH_EN
        flush_pend_d = flush_pend_q;
`endif
        case (state_q)
            IDLE: begin
                if (READ && !hit) begin
                    busywait   = 1'b1;
                    miss_blk_d = ADDRESS[31:4];
                    state_d    = FETCH;
                end
`ifdef ICACHE_FLUSH_EN
                if (FLUSH || flush_pend_q) begin
                    valid_d      = '0;
                    flush_pend_d = 1'b0;
                end
`endif
            end
            FETCH: begin
                busywait = 1'b1;
                if (!MEM_BUSYWAIT) begin
                    state_d = UPDATE;
                end
`ifdef ICACHE_FLUSH_EN
                if (FLUSH) begin
                    flush_pend_d = 1'b1;
                end
`endif
            end
            UPDATE: begin
                busywait                  = 1'b1;
                tags_d[miss_blk_q[3:0]]   = miss_blk_q;
                valid_d[miss_blk_q[3:0]]  = 1'b1;
                state_d                   = IDLE;
`ifdef ICACHE_FLUSH_EN
                if (FLUSH) begin
                    flush_pend_d = 1'b1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            tags_q     <= '0;
            valid_q    <= '0;
            miss_blk_q <= '0;
`ifdef ICACHE_FLUSH_EN
            flush_pend_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tags_q     <= tags_d;
            valid_q    <= valid_d;
            miss_blk_q <= miss_blk_d;
`ifdef ICACHE_FLUSH_EN
            flush_pend_q <= flush_pend_d;
`endif
        end
    end

    // Memory strobes decode registered state only, so they cannot glitch.
    assign TAG_ARRAY   = tags_q;
    assign VALID_ARRAY = valid_q;
    assign BUSYWAIT    = busywait;
    assign MEM_READ    = (state_q == FETCH);
    assign FILL_EN     = (state_q == UPDATE);
    assign MEM_ADDRESS = miss_blk_q;

endmodule
